evaluate_taper: RTL

Downstream stage of `evaluate_general`: it consumes the separate middlegame/endgame scores and blends them by game phase. It computes the phase from the same board, performs a signed tapered blend, and orients the result to the side to move. It presents one handshaked evaluation per board to the search controller and owns the `clear_eval` handshake back to `evaluate_general`.

---
 rtl/evaluate_taper_pkg.sv | 37 +++
 rtl/evaluate_taper_if.sv | 35 +++
 rtl/evaluate_taper_game_phase.sv | 59 +++++
 rtl/evaluate_taper.sv | 134 +++++++++++++
 4 files changed

// File: rtl/evaluate_taper_pkg.sv
// Shared constants for the tapered evaluation stage: board/piece encoding,
// phase weights and the controller state codes.
package evaluate_taper_pkg;

    localparam int PIECE_WIDTH = 4;
    localparam int NUM_SQUARES = 64;
    localparam int BOARD_WIDTH = NUM_SQUARES * PIECE_WIDTH;

    // Low three bits of a square code give the piece kind; bit 3 is set for black.
    typedef enum logic [2:0] {
        PIECE_EMPTY = 3'd0,
        PIECE_PAWN  = 3'd1,
        PIECE_KNIT  = 3'd2,
        PIECE_BISH  = 3'd3,
        PIECE_ROOK  = 3'd4,
        PIECE_QUEN  = 3'd5,
        PIECE_KING  = 3'd6
    } piece_kind_e;

    localparam int COLOR_BIT = 3;

    localparam int PHASE_KNIT        = 1;
    localparam int PHASE_BISH        = 1;
    localparam int PHASE_ROOK        = 2;
    localparam int PHASE_QUEN        = 4;
    localparam int PHASE_MAX_DEFAULT = 24;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_GEN = 2'd1;
    localparam logic [1:0] ST_BLEND    = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    function automatic piece_kind_e square_kind(input logic [PIECE_WIDTH-1:0] code);
        return piece_kind_e'(code[2:0]);
    endfunction

endpackage

// File: rtl/evaluate_taper_if.sv
// Board/score handshake bundle between evaluate_general, the search
// controller (master side) and evaluate_taper (slave side).
interface evaluate_taper_if
    import evaluate_taper_pkg::*;
#(
    parameter int EVAL_WIDTH = 32
) ();

    logic                         board_valid;
    logic [BOARD_WIDTH-1:0]       board;
    logic                         white_to_move;
    logic                         gen_eval_valid;
    logic signed [EVAL_WIDTH-1:0] gen_eval_mg;
    logic signed [EVAL_WIDTH-1:0] gen_eval_eg;
    logic                         gen_insufficient;
    logic                         gen_clear_eval;
    logic                         clear_eval;
    logic signed [EVAL_WIDTH-1:0] eval;
    logic                         eval_valid;

    modport master (
        output board_valid, board, white_to_move,
        output gen_eval_valid, gen_eval_mg, gen_eval_eg, gen_insufficient,
        output clear_eval,
        input  gen_clear_eval, eval, eval_valid
    );

    modport slave (
        input  board_valid, board, white_to_move,
        input  gen_eval_valid, gen_eval_mg, gen_eval_eg, gen_insufficient,
        input  clear_eval,
        output gen_clear_eval, eval, eval_valid
    );

endinterface

// File: rtl/evaluate_taper_game_phase.sv
// Game-phase pipeline: per-kind piece popcounts, then weighted sum clamped
// to PHASE_MAX. Two cycles from board to phase_o, no handshake.
module evaluate_taper_game_phase
    import evaluate_taper_pkg::*;
#(
    parameter int PHASE_MAX = PHASE_MAX_DEFAULT,
    parameter int PHASE_W   = $clog2(PHASE_MAX + 1)
) (
    input  logic                   clk,
    input  logic [BOARD_WIDTH-1:0] board_i,
    output logic [PHASE_W-1:0]     phase_o
);

    localparam int CNT_W = $clog2(NUM_SQUARES + 1);

    logic [CNT_W-1:0] knit_d, bish_d, rook_d, quen_d;
    logic [CNT_W-1:0] knit_q, bish_q, rook_q, quen_q;
    logic [31:0]      weighted;
    logic [PHASE_W-1:0] phase_d, phase_q;

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        knit_d = '0;
        bish_d = '0;
        rook_d = '0;
        quen_d = '0;
        for (int sq = 0; sq < NUM_SQUARES; sq++) begin
            case (square_kind(board_i[sq*PIECE_WIDTH +: PIECE_WIDTH]))
                PIECE_KNIT: knit_d = knit_d + CNT_W'(1);
                PIECE_BISH: bish_d = bish_d + CNT_W'(1);
                PIECE_ROOK: rook_d = rook_d + CNT_W'(1);
                PIECE_QUEN: quen_d = quen_d + CNT_W'(1);
                default:    ;
            endcase
        end
    end

    always_comb begin
        weighted = 32'(knit_q) * 32'(PHASE_KNIT)
                 + 32'(bish_q) * 32'(PHASE_BISH)
                 + 32'(rook_q) * 32'(PHASE_ROOK)
                 + 32'(quen_q) * 32'(PHASE_QUEN);
        phase_d  = (weighted > 32'(PHASE_MAX)) ? PHASE_W'(PHASE_MAX) : PHASE_W'(weighted);
    end

    // NOTE: pure datapath registers carry no reset; the controller's
    // phase-valid flag decides when their contents mean anything.
    always_ff @(posedge clk) begin
        knit_q  <= knit_d;
        bish_q  <= bish_d;
        rook_q  <= rook_d;
        quen_q  <= quen_d;
        phase_q <= phase_d;
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/evaluate_taper.sv
// Tapered evaluation: blends evaluate_general's mg/eg scores by game phase,
// orients to the side to move and hands one result per board to the search.
module evaluate_taper
    import evaluate_taper_pkg::*;
#(
    parameter int EVAL_WIDTH = 32,
    parameter int PHASE_MAX  = PHASE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    evaluate_taper_if.slave   bus
);

    localparam int SUM_W   = EVAL_WIDTH + 6;
    localparam int PHASE_W = $clog2(PHASE_MAX + 1);

    localparam logic signed [SUM_W-1:0]      PHASE_MAX_S = SUM_W'(PHASE_MAX);
    localparam logic signed [EVAL_WIDTH-1:0] EVAL_MAX    = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
    localparam logic signed [EVAL_WIDTH-1:0] EVAL_MIN    = {1'b1, {(EVAL_WIDTH-1){1'b0}}};

    logic [1:0] state_q, state_d;
    logic       board_valid_q;
    logic       board_rise;
    logic       gen_accept;

    logic [BOARD_WIDTH-1:0] board_q;
    logic                   wtm_q;

    logic signed [EVAL_WIDTH-1:0] mg_q, eg_q;
    logic                         insuf_q;

    logic [PHASE_W-1:0] phase;
    logic [1:0]         phase_cnt_q;
    logic               phase_valid;

    logic [1:0] blend_cnt_q;
    logic       blend_step;

    logic signed [SUM_W-1:0]      mg_ext, eg_ext, ph_ext, sum_d, sum_q;
    logic signed [EVAL_WIDTH-1:0] quot_d, quot_q, neg_q, eval_d, eval_q;
    logic                         gen_clear_q;

    evaluate_taper_game_phase #(
        .PHASE_MAX (PHASE_MAX),
        .PHASE_W   (PHASE_W)
    ) u_game_phase (
        .clk     (clk),
        .board_i (board_q),
        .phase_o (phase)
    );

    assign board_rise  = bus.board_valid & ~board_valid_q;
    assign gen_accept  = (state_q == ST_WAIT_GEN) && bus.gen_eval_valid;
    assign phase_valid = (phase_cnt_q == 2'd2);
    // BLEND only advances once the phase pipeline has caught up with the board.
    assign blend_step  = (state_q == ST_BLEND) && phase_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (board_rise)                          state_d = ST_WAIT_GEN;
            ST_WAIT_GEN: if (bus.gen_eval_valid)                  state_d = ST_BLEND;
            ST_BLEND:    if (blend_step && blend_cnt_q == 2'd2)   state_d = ST_DONE;
            ST_DONE:     if (bus.clear_eval)                      state_d = ST_IDLE;
            default:                                              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mg_ext = SUM_W'(mg_q);
        eg_ext = SUM_W'(eg_q);
        ph_ext = SUM_W'({1'b0, phase});
        sum_d  = mg_ext * ph_ext + eg_ext * (PHASE_MAX_S - ph_ext);
        // Signed division truncates toward zero; |sum/PHASE_MAX| fits EVAL_WIDTH.
        quot_d = EVAL_WIDTH'(sum_q / PHASE_MAX_S);
        // Only the most negative quotient can overflow when negated.
        neg_q  = (quot_q == EVAL_MIN) ? EVAL_MAX : -quot_q;
        if (insuf_q)
            eval_d = '0;
        else
            eval_d = wtm_q ? quot_q : neg_q;
    end

    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            board_valid_q <= 1'b0;
            phase_cnt_q   <= '0;
            blend_cnt_q   <= '0;
            gen_clear_q   <= 1'b0;
            eval_q        <= '0;
        end else begin
            state_q       <= state_d;
            board_valid_q <= bus.board_valid;
            gen_clear_q   <= gen_accept;

            if (state_q == ST_IDLE)
                phase_cnt_q <= '0;
            else if (!phase_valid)
                phase_cnt_q <= phase_cnt_q + 2'd1;

            if (gen_accept)
                blend_cnt_q <= '0;
            else if (blend_step)
                blend_cnt_q <= (blend_cnt_q == 2'd2) ? 2'd0 : blend_cnt_q + 2'd1;

            if (blend_step && blend_cnt_q == 2'd2)
                eval_q <= eval_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && board_rise) begin
            board_q <= bus.board;
            wtm_q   <= bus.white_to_move;
        end
        if (gen_accept) begin
            mg_q    <= bus.gen_eval_mg;
            eg_q    <= bus.gen_eval_eg;
            insuf_q <= bus.gen_insufficient;
        end
        if (blend_step && blend_cnt_q == 2'd0)
            sum_q <= sum_d;
        if (blend_step && blend_cnt_q == 2'd1)
            quot_q <= quot_d;
    end

    assign bus.gen_clear_eval = gen_clear_q;
    assign bus.eval           = eval_q;
    assign bus.eval_valid     = (state_q == ST_DONE);

endmodule
